// File: rtl/round_key_reader.sv
// Round-key store and sequencer.
// Captures expanded round keys from the key-expansion write port and replays them to the
// cipher round datapath over a valid/ready stream: ascending for encryption, descending for
// decryption. Each key is fetched with a registered array read, then held until accepted.
module round_key_reader #(
    parameter int unsigned KEY_BITS  = 128,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DEPTH     = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_e,
    input  logic [ADDR_BITS-1:0] round_key_addr,
    input  logic [KEY_BITS-1:0]  round_key,
    input  logic                 keygen_done,
    input  logic [ADDR_BITS-1:0] rounds_total,
    input  logic                 start,
    input  logic                 decrypt,
    input  logic                 rk_ready,
    output logic                 rk_valid,
    output logic [KEY_BITS-1:0]  rk_data,
    output logic [ADDR_BITS-1:0] rk_idx,
    output logic                 rk_last,
    output logic                 keys_loaded,
    output logic                 busy,
    output logic                 done,
    output logic                 abort,
    output logic                 cfg_err
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StFetch   = 2'd1;
    localparam logic [1:0] StPresent = 2'd2;

    localparam logic [ADDR_BITS-1:0] LastSlot = ADDR_BITS'(DEPTH - 1);

    logic [KEY_BITS-1:0] mem [DEPTH];

    logic                 wr_ok;
    logic                 rekey;
    logic                 cfg_ok;

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 dir_q, dir_d;
    logic [ADDR_BITS-1:0] last_idx_q;
    logic                 keys_loaded_q;
    logic                 cfg_err_q;
    logic                 rk_valid_q, rk_valid_d;
    logic [KEY_BITS-1:0]  rk_data_q, rk_data_d;
    logic [ADDR_BITS-1:0] rk_idx_q, rk_idx_d;
    logic                 rk_last_q, rk_last_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;

    assign wr_ok  = w_e && (round_key_addr <= LastSlot);
    // Any write to slot 0 starts a new key schedule.
    assign rekey  = w_e && (round_key_addr == '0);
    assign cfg_ok = rounds_total <= LastSlot;

    // Key array write port; out-of-range slots are silently dropped, contents never reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[round_key_addr] <= round_key;
        end
    end

    // Key-set bookkeeping: last index, loaded flag and configuration error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx_q    <= '0;
            keys_loaded_q <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q <= keygen_done && !cfg_ok;
            if (keygen_done && cfg_ok) begin
                last_idx_q <= rounds_total;
            end
            // A slot-0 write in the same cycle as completion wins: the set is not yet complete.
            if (rekey) begin
                keys_loaded_q <= 1'b0;
            end else if (keygen_done) begin
                keys_loaded_q <= cfg_ok;
            end
        end
    end

    // Replay sequencer next-state and output staging.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dir_d      = dir_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        rk_last_d  = rk_last_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        if (rekey && (state_q != StIdle)) begin
            // Re-key kills the pass; the keys being replayed are no longer coherent.
            state_d    = StIdle;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
            abort_d    = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start && keys_loaded_q) begin
                        dir_d   = decrypt;
                        ptr_d   = decrypt ? last_idx_q : '0;
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    rk_data_d  = mem[ptr_q];
                    rk_idx_d   = ptr_q;
                    rk_last_d  = dir_q ? (ptr_q == '0) : (ptr_q == last_idx_q);
                    rk_valid_d = 1'b1;
                    state_d    = StPresent;
                end
                StPresent: begin
                    if (rk_ready) begin
                        rk_valid_d = 1'b0;
                        if (rk_last_q) begin
                            rk_last_d = 1'b0;
                            done_d    = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            // rk_last stops the walk at a bound, so ptr never wraps.
                            ptr_d   = dir_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
                            state_d = StFetch;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Sequencer state and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            dir_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            dir_q      <= dir_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            rk_last_q  <= rk_last_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign rk_valid    = rk_valid_q;
    assign rk_data     = rk_data_q;
    assign rk_idx      = rk_idx_q;
    assign rk_last     = rk_last_q;
    assign keys_loaded = keys_loaded_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign abort       = abort_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_round_key_reader.sv
// Directed bench for round_key_reader: expected keys are queued when a pass is started and
// popped as the DUT presents them. Inputs change and outputs are sampled on the falling edge.
module tb_round_key_reader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         w_e = 1'b0;
    logic [3:0]   round_key_addr = '0;
    logic [127:0] round_key = '0;
    logic         keygen_done = 1'b0;
    logic [3:0]   rounds_total = '0;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic         rk_ready = 1'b1;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         keys_loaded;
    logic         busy;
    logic         done;
    logic         abort;
    logic         cfg_err;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    round_key_reader #(
        .KEY_BITS (128),
        .ADDR_BITS(4),
        .DEPTH    (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .w_e           (w_e),
        .round_key_addr(round_key_addr),
        .round_key     (round_key),
        .keygen_done   (keygen_done),
        .rounds_total  (rounds_total),
        .start         (start),
        .decrypt       (decrypt),
        .rk_ready      (rk_ready),
        .rk_valid      (rk_valid),
        .rk_data       (rk_data),
        .rk_idx        (rk_idx),
        .rk_last       (rk_last),
        .keys_loaded   (keys_loaded),
        .busy          (busy),
        .done          (done),
        .abort         (abort),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_idx(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_key(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] key_of(input int set, input int i);
        if (set == 0) return 128'hA0 + 128'(i);
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    task automatic chk_quiet(input string tag);
        chk_bit({tag, "_valid"}, rk_valid, 1'b0);
        chk_key({tag, "_data"}, rk_data, '0);
        chk_idx({tag, "_idx"}, rk_idx, 4'd0);
        chk_bit({tag, "_last"}, rk_last, 1'b0);
        chk_bit({tag, "_loaded"}, keys_loaded, 1'b0);
        chk_bit({tag, "_busy"}, busy, 1'b0);
        chk_bit({tag, "_done"}, done, 1'b0);
        chk_bit({tag, "_abort"}, abort, 1'b0);
        chk_bit({tag, "_cfg_err"}, cfg_err, 1'b0);
    endtask

    task automatic write_key(input int a, input logic [127:0] d);
        w_e = 1'b1;
        round_key_addr = 4'(a);
        round_key = d;
        @(negedge clk);
        w_e = 1'b0;
    endtask

    task automatic load_set(input int set, input int last);
        for (int i = 0; i <= last; i++) begin
            write_key(i, key_of(set, i));
            if (i == 0) chk_bit("loaded_clr_addr0", keys_loaded, 1'b0);
        end
        keygen_done = 1'b1;
        rounds_total = 4'(last);
        @(negedge clk);
        keygen_done = 1'b0;
        chk_bit("loaded_set", keys_loaded, 1'b1);
        chk_bit("load_cfg_err", cfg_err, 1'b0);
    endtask

    task automatic start_ignored(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_bit({tag, "_valid"}, rk_valid, 1'b0);
            chk_bit({tag, "_busy"}, busy, 1'b0);
            @(negedge clk);
        end
    endtask

    // cut_kind: 0 = full pass, 1 = re-key at cut_at, 2 = reset at cut_at.
    task automatic run_pass(input int set, input bit dec, input int last, input int stall_at,
                            input int cut_at, input int cut_kind);
        exp_t e;
        int   guard = 0;
        for (int k = 0; k <= last; k++) begin
            e.idx  = 4'(dec ? last - k : k);
            e.data = key_of(set, int'(e.idx));
            e.last = (k == last);
            exp_q.push_back(e);
            if (cut_kind != 0 && int'(e.idx) == cut_at) break;
        end
        start = 1'b1;
        decrypt = dec;
        @(negedge clk);
        start = 1'b0;
        decrypt = 1'b0;
        chk_bit("lat_fetch_valid", rk_valid, 1'b0);
        chk_bit("lat_fetch_busy", busy, 1'b1);
        @(negedge clk);
        chk_bit("lat_first_valid", rk_valid, 1'b1);
        while (exp_q.size() > 0) begin
            if (guard > 100) begin
                chk_int("pass_timeout_left", exp_q.size(), 0);
                exp_q.delete();
                break;
            end
            guard++;
            if (!rk_valid) begin
                @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            chk_idx("rk_idx", rk_idx, e.idx);
            chk_key("rk_data", rk_data, e.data);
            chk_bit("rk_last", rk_last, e.last);
            chk_bit("busy_present", busy, 1'b1);
            if (int'(e.idx) == stall_at) begin
                rk_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk_bit("stall_valid", rk_valid, 1'b1);
                    chk_idx("stall_idx", rk_idx, e.idx);
                    chk_key("stall_data", rk_data, e.data);
                end
                rk_ready = 1'b1;
            end
            if (cut_kind == 1 && int'(e.idx) == cut_at) begin
                rk_ready = 1'b0;
                w_e = 1'b1;
                round_key_addr = 4'd0;
                round_key = key_of(set, 0);
                @(negedge clk);
                w_e = 1'b0;
                rk_ready = 1'b1;
                chk_bit("abort_pulse", abort, 1'b1);
                chk_bit("abort_valid", rk_valid, 1'b0);
                chk_bit("abort_loaded", keys_loaded, 1'b0);
                chk_bit("abort_busy", busy, 1'b0);
                chk_bit("abort_done", done, 1'b0);
                @(negedge clk);
                chk_bit("abort_pulse_end", abort, 1'b0);
            end else if (cut_kind == 2 && int'(e.idx) == cut_at) begin
                rk_ready = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk_quiet("reset_mid");
                reset = 1'b0;
                rk_ready = 1'b1;
                @(negedge clk);
                chk_bit("reset_mid_done", done, 1'b0);
                chk_bit("reset_mid_abort", abort, 1'b0);
                chk_bit("reset_mid_valid", rk_valid, 1'b0);
            end else begin
                @(negedge clk);
                chk_bit("gap_valid", rk_valid, 1'b0);
                if (e.last) begin
                    chk_bit("done_pulse", done, 1'b1);
                    chk_bit("done_busy", busy, 1'b0);
                    @(negedge clk);
                    chk_bit("done_pulse_end", done, 1'b0);
                    chk_bit("idle_valid", rk_valid, 1'b0);
                end else begin
                    chk_bit("gap_done", done, 1'b0);
                    @(negedge clk);
                    chk_bit("steady_valid", rk_valid, 1'b1);
                end
            end
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");

        // Start with no key set is ignored.
        start_ignored("no_keys");

        // Out-of-range rounds_total rejects the set.
        for (int i = 0; i <= 14; i++) write_key(i, key_of(1, i));
        keygen_done = 1'b1;
        rounds_total = 4'd15;
        @(negedge clk);
        keygen_done = 1'b0;
        chk_bit("cfg_err_pulse", cfg_err, 1'b1);
        chk_bit("cfg_err_loaded", keys_loaded, 1'b0);
        @(negedge clk);
        chk_bit("cfg_err_end", cfg_err, 1'b0);
        start_ignored("bad_cfg");

        // AES-128 encryption pass with 5 cycles of backpressure at idx 3.
        load_set(0, 10);
        run_pass(0, 1'b0, 10, 3, -1, 0);

        // AES-256 decryption pass.
        load_set(1, 14);
        run_pass(1, 1'b1, 14, -1, -1, 0);

        // Re-key while idx 5 is presented.
        run_pass(1, 1'b0, 14, -1, 5, 1);
        start_ignored("after_abort");

        // Slot-0 write coinciding with completion keeps the set unloaded.
        load_set(0, 10);
        w_e = 1'b1;
        round_key_addr = 4'd0;
        round_key = key_of(0, 0);
        keygen_done = 1'b1;
        rounds_total = 4'd10;
        @(negedge clk);
        w_e = 1'b0;
        keygen_done = 1'b0;
        chk_bit("clear_wins", keys_loaded, 1'b0);

        // Reset while idx 7 is presented.
        load_set(0, 10);
        run_pass(0, 1'b0, 10, -1, 7, 2);
        start_ignored("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
